// File: rtl/chip8_boot_pkg.sv
// Shared types and constant font tables for the CHIP-8 boot sequencer.
// The HIRES state exists only when CHIP8_HIRES_FONT_EN is defined.
package chip8_boot_pkg;

    typedef enum logic [2:0] {
        ST_FONT     = 3'd0,
`ifdef CHIP8_HIRES_FONT_EN
        ST_HIRES    = 3'd1,
`endif
        ST_CLEAR    = 3'd2,
        ST_ROM_WAIT = 3'd3,
        ST_READY    = 3'd4
    } boot_state_e;

    localparam int LORES_GLYPH_BYTES = 5;
    localparam int HIRES_GLYPH_BYTES = 10;
    localparam int GLYPH_COUNT       = 16;
    localparam int LORES_BYTES       = GLYPH_COUNT * LORES_GLYPH_BYTES;
    localparam int HIRES_BYTES       = GLYPH_COUNT * HIRES_GLYPH_BYTES;

    localparam logic [7:0] LORES_FONT [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    localparam logic [7:0] HIRES_FONT [0:159] = '{
        8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hE7, 8'h7E, 8'h3C,
        8'h18, 8'h38, 8'h58, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C,
        8'h3E, 8'h7F, 8'hC3, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hFF, 8'hFF,
        8'h3C, 8'h7E, 8'hC3, 8'h03, 8'h0E, 8'h0E, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h06, 8'h0E, 8'h1E, 8'h36, 8'h66, 8'hC6, 8'hFF, 8'hFF, 8'h06, 8'h06,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFC, 8'hFE, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h3E, 8'h7C, 8'hC0, 8'hC0, 8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'hFF, 8'hFF, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h60,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7F, 8'h3F, 8'h03, 8'h03, 8'h3E, 8'h7C,
        8'h18, 8'h3C, 8'h66, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3,
        8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'hFE, 8'hFE, 8'hC3, 8'hC3, 8'hFE, 8'hFC,
        8'h3C, 8'h7E, 8'hC3, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC3, 8'h7E, 8'h3C,
        8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFE, 8'hFC,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0
    };

    // True when [base, base+len-1] lies inside a 2^addr_w byte space.
    function automatic bit region_fits(input int base, input int len, input int addr_w);
        return (len == 0) || ((base >= 0) && (base + len - 1 <= (1 << addr_w) - 1));
    endfunction

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational index -> font byte lookup; the hi-res table is selectable
// only when CHIP8_HIRES_FONT_EN is defined.
module chip8_font_rom
    import chip8_boot_pkg::*;
(
    input  logic       sel_i,
    input  logic [7:0] index_i,
    output logic [7:0] byte_o
);

    always_comb begin
        byte_o = 8'h00;
`ifdef CHIP8_HIRES_FONT_EN
        if (sel_i) begin
            if (index_i < 8'(HIRES_BYTES)) byte_o = HIRES_FONT[index_i];
        end else if (index_i < 8'(LORES_BYTES)) begin
            byte_o = LORES_FONT[index_i[6:0]];
        end
`else
        if (!sel_i && (index_i < 8'(LORES_BYTES))) byte_o = LORES_FONT[index_i[6:0]];
`endif
    end

endmodule

// File: rtl/chip8_boot_sequencer.sv
// Power-on / re-init sequencer: writes fonts, zero-fills a region, then waits on the ROM loader.
// Define CHIP8_HIRES_FONT_EN to also write the 160-byte hi-res font after the lo-res one.
module chip8_boot_sequencer
    import chip8_boot_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FONT_BASE  = 'h000,
    parameter int HIRES_BASE = 'h050,
    parameter int CLEAR_BASE = 'h0F0,
    parameter int CLEAR_LEN  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              reinit,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready,
    output logic              rom_start,
    input  logic              rom_done,
    output logic              font_ready,
    output logic              system_ready,
    output logic              busy
);

    localparam int IDX_W = (CLEAR_LEN > 256) ? $clog2(CLEAR_LEN) : 8;
`ifdef CHIP8_HIRES_FONT_EN
    localparam int HIRES_LEN = HIRES_BYTES;
`else
    localparam int HIRES_LEN = 0;
`endif

    if (DATA_W < 8) begin : g_data_w_err
        $error("chip8_boot_sequencer: DATA_W must be at least 8");
    end
    if (!region_fits(FONT_BASE, LORES_BYTES, ADDR_W)) begin : g_font_err
        $error("chip8_boot_sequencer: lo-res font region exceeds address space");
    end
    if (!region_fits(HIRES_BASE, HIRES_LEN, ADDR_W)) begin : g_hires_err
        $error("chip8_boot_sequencer: hi-res font region exceeds address space");
    end
    if (!region_fits(CLEAR_BASE, CLEAR_LEN, ADDR_W)) begin : g_clear_err
        $error("chip8_boot_sequencer: clear region exceeds address space");
    end

    boot_state_e       state_q, state_d, after_fonts;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              font_ready_q, font_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, base_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rom_start_q, system_ready_q, busy_q;
    logic              accept, rom_sel;
    logic [7:0]        rom_byte;

    assign accept      = mem_we_q & mem_wready;
    assign after_fonts = (CLEAR_LEN > 0) ? ST_CLEAR : ST_ROM_WAIT;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        font_ready_d = font_ready_q;
        case (state_q)
            ST_FONT: if (accept) begin
                if (idx_q == IDX_W'(LORES_BYTES - 1)) begin
                    idx_d = '0;
`ifdef CHIP8_HIRES_FONT_EN
                    state_d = ST_HIRES;
`else
                    state_d      = after_fonts;
                    font_ready_d = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef CHIP8_HIRES_FONT_EN
            ST_HIRES: if (accept) begin
                if (idx_q == IDX_W'(HIRES_BYTES - 1)) begin
                    idx_d        = '0;
                    state_d      = after_fonts;
                    font_ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            ST_CLEAR: if (accept) begin
                if (idx_q == IDX_W'(CLEAR_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = ST_ROM_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ROM_WAIT: if (rom_done) state_d = ST_READY;
            ST_READY: if (reinit) begin
                state_d      = ST_FONT;
                idx_d        = '0;
                font_ready_d = 1'b0;
            end
            default: begin
                state_d = ST_FONT;
                idx_d   = '0;
            end
        endcase
    end

`ifdef CHIP8_HIRES_FONT_EN
    assign rom_sel = (state_d == ST_HIRES);
`else
    assign rom_sel = 1'b0;
`endif

    chip8_font_rom u_font_rom (
        .sel_i   (rom_sel),
        .index_i (idx_d[7:0]),
        .byte_o  (rom_byte)
    );

    // Outputs are registered from the upcoming position so the write port never bubbles.
    always_comb begin
        mem_we_d    = 1'b0;
        base_d      = '0;
        mem_wdata_d = '0;
        case (state_d)
            ST_FONT: begin
                mem_we_d    = 1'b1;
                base_d      = ADDR_W'(FONT_BASE);
                mem_wdata_d = DATA_W'(rom_byte);
            end
`ifdef CHIP8_HIRES_FONT_EN
            ST_HIRES: begin
                mem_we_d    = 1'b1;
                base_d      = ADDR_W'(HIRES_BASE);
                mem_wdata_d = DATA_W'(rom_byte);
            end
`endif
            ST_CLEAR: begin
                mem_we_d = 1'b1;
                base_d   = ADDR_W'(CLEAR_BASE);
            end
            default: ;
        endcase
        mem_addr_d = mem_we_d ? (base_d + ADDR_W'(idx_d)) : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_FONT;
            idx_q          <= '0;
            font_ready_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rom_start_q    <= 1'b0;
            system_ready_q <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            font_ready_q   <= font_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rom_start_q    <= (state_d == ST_ROM_WAIT);
            system_ready_q <= (state_d == ST_READY);
            busy_q         <= (state_d != ST_ROM_WAIT) && (state_d != ST_READY);
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign rom_start    = rom_start_q;
    assign font_ready   = font_ready_q;
    assign system_ready = system_ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_chip8_boot_sequencer.sv
// Directed bench for chip8_boot_sequencer; honours CHIP8_HIRES_FONT_EN when defined.
// A second instance with CLEAR_LEN=0 and wready tied high checks the CLEAR skip.
module tb_chip8_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst, reinit, wready, rom_done;
    logic        mem_we, rom_start, font_ready, system_ready, busy;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        d0_we, d0_rom_start, d0_font_ready, d0_system_ready, d0_busy;
    logic [11:0] d0_addr;
    logic [7:0]  d0_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef CHIP8_HIRES_FONT_EN
    localparam int FONT_END = 240;
`else
    localparam int FONT_END = 80;
`endif

    logic [7:0] lores_exp [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

`ifdef CHIP8_HIRES_FONT_EN
    logic [7:0] hires_exp [0:159] = '{
        8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hE7, 8'h7E, 8'h3C,
        8'h18, 8'h38, 8'h58, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C,
        8'h3E, 8'h7F, 8'hC3, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hFF, 8'hFF,
        8'h3C, 8'h7E, 8'hC3, 8'h03, 8'h0E, 8'h0E, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h06, 8'h0E, 8'h1E, 8'h36, 8'h66, 8'hC6, 8'hFF, 8'hFF, 8'h06, 8'h06,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFC, 8'hFE, 8'h03, 8'hC3, 8'h7E, 8'h3C,
        8'h3E, 8'h7C, 8'hC0, 8'hC0, 8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'hFF, 8'hFF, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h60,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h7E, 8'hC3, 8'hC3, 8'h7E, 8'h3C,
        8'h3C, 8'h7E, 8'hC3, 8'hC3, 8'h7F, 8'h3F, 8'h03, 8'h03, 8'h3E, 8'h7C,
        8'h18, 8'h3C, 8'h66, 8'hC3, 8'hC3, 8'hFF, 8'hFF, 8'hC3, 8'hC3, 8'hC3,
        8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'hFE, 8'hFE, 8'hC3, 8'hC3, 8'hFE, 8'hFC,
        8'h3C, 8'h7E, 8'hC3, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC3, 8'h7E, 8'h3C,
        8'hFC, 8'hFE, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFE, 8'hFC,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0
    };
`endif

    chip8_boot_sequencer dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .reinit       (reinit),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wready   (wready),
        .rom_start    (rom_start),
        .rom_done     (rom_done),
        .font_ready   (font_ready),
        .system_ready (system_ready),
        .busy         (busy)
    );

    chip8_boot_sequencer #(.CLEAR_LEN(0)) dut0 (
        .clk_in       (clk),
        .rst_in       (rst),
        .reinit       (1'b0),
        .mem_we       (d0_we),
        .mem_addr     (d0_addr),
        .mem_wdata    (d0_wdata),
        .mem_wready   (1'b1),
        .rom_start    (d0_rom_start),
        .rom_done     (1'b0),
        .font_ready   (d0_font_ready),
        .system_ready (d0_system_ready),
        .busy         (d0_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Font write n of the combined sequence (lo-res then, if present, hi-res).
    function automatic logic [31:0] exp_addr(input int n);
        if (n < 80) return 32'(n);
        return 32'('h050 + n - 80);
    endfunction

    function automatic logic [31:0] exp_data(input int n);
        if (n < 80) return 32'(lores_exp[n]);
`ifdef CHIP8_HIRES_FONT_EN
        return 32'(hires_exp[n - 80]);
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},           32'(mem_we), 32'd0);
        check({tag, "_addr"},         32'(mem_addr), 32'd0);
        check({tag, "_wdata"},        32'(mem_wdata), 32'd0);
        check({tag, "_rom_start"},    32'(rom_start), 32'd0);
        check({tag, "_font_ready"},   32'(font_ready), 32'd0);
        check({tag, "_system_ready"}, 32'(system_ready), 32'd0);
        check({tag, "_busy"},         32'(busy), 32'd1);
    endtask

    initial begin
        int exp_idx;
        int guard;
        logic phase;

        rst = 1'b1; reinit = 1'b0; wready = 1'b1; rom_done = 1'b0;
        tick; tick;
        check_reset_values("reset");
        $display("step reset: checks so far total=%0d bad=%0d", total, bad);

        // Back-to-back font writes starting the first cycle after reset
        rst = 1'b0;
        for (int n = 0; n < FONT_END; n++) begin
            tick;
            check("font_we", 32'(mem_we), 32'd1);
            check("font_addr", 32'(mem_addr), exp_addr(n));
            check("font_data", 32'(mem_wdata), exp_data(n));
            check("font_ready_low", 32'(font_ready), 32'd0);
            if (n == 5) check("lores5_data", 32'(mem_wdata), 32'h20);
            if (n == 79) begin
                check("lores79_addr", 32'(mem_addr), 32'h04F);
                check("lores79_data", 32'(mem_wdata), 32'h80);
            end
        end
        $display("step font: %0d writes checked, bad=%0d", FONT_END, bad);

        // Zero-fill with no bubble after the last font byte
        for (int i = 0; i < 16; i++) begin
            tick;
            check("clear_font_ready", 32'(font_ready), 32'd1);
            check("clear_we", 32'(mem_we), 32'd1);
            check("clear_addr", 32'(mem_addr), 32'h0F0 + 32'(i));
            check("clear_data", 32'(mem_wdata), 32'd0);
            check("clear_busy", 32'(busy), 32'd1);
            if (i == 0) begin
                check("noclear_rom_start", 32'(d0_rom_start), 32'd1);
                check("noclear_we", 32'(d0_we), 32'd0);
                check("noclear_font_ready", 32'(d0_font_ready), 32'd1);
            end
            if (i == 15) rom_done = 1'b1;
        end
        $display("step clear: 16 writes checked, bad=%0d", bad);

        tick;
        rom_done = 1'b0;
        check("romwait_rom_start", 32'(rom_start), 32'd1);
        check("romwait_we", 32'(mem_we), 32'd0);
        check("romwait_busy", 32'(busy), 32'd0);
        check("romwait_sysready", 32'(system_ready), 32'd0);
        tick;
        check("early_done_ignored", 32'(system_ready), 32'd0);
        check("early_done_rom_start", 32'(rom_start), 32'd1);
        $display("step rom_wait: entered, early rom_done ignored, bad=%0d", bad);

        reinit = 1'b1;
        tick;
        reinit = 1'b0;
        check("reinit_romwait_rom_start", 32'(rom_start), 32'd1);
        check("reinit_romwait_busy", 32'(busy), 32'd0);
        check("reinit_romwait_we", 32'(mem_we), 32'd0);
        $display("step reinit in rom_wait: ignored, bad=%0d", bad);

        rom_done = 1'b1;
        tick;
        rom_done = 1'b0;
        check("ready_sysready", 32'(system_ready), 32'd1);
        check("ready_rom_start", 32'(rom_start), 32'd0);
        check("ready_busy", 32'(busy), 32'd0);
        check("ready_font_ready", 32'(font_ready), 32'd1);
        tick;
        check("ready_hold", 32'(system_ready), 32'd1);
        $display("step rom_done: system_ready raised, bad=%0d", bad);

        reinit = 1'b1;
        tick;
        reinit = 1'b0;
        check("reinit_sysready", 32'(system_ready), 32'd0);
        check("reinit_font_ready", 32'(font_ready), 32'd0);
        check("reinit_busy", 32'(busy), 32'd1);
        check("reinit_we", 32'(mem_we), 32'd1);
        check("reinit_addr", 32'(mem_addr), 32'd0);
        check("reinit_data", 32'(mem_wdata), 32'hF0);
        $display("step reinit in ready: sequence restarted, bad=%0d", bad);

        // Replay with wready alternating; each byte must appear in order, held while stalled
        exp_idx = 0;
        guard   = 0;
        phase   = 1'b0;
        while (exp_idx < FONT_END && guard < 2000) begin
            check("toggle_we", 32'(mem_we), 32'd1);
            check("toggle_addr", 32'(mem_addr), exp_addr(exp_idx));
            check("toggle_data", 32'(mem_wdata), exp_data(exp_idx));
            wready = phase;
            tick;
            if (wready) exp_idx++;
            phase = ~phase;
            guard++;
        end
        wready = 1'b1;
        check("toggle_count", 32'(exp_idx), 32'(FONT_END));
        check("toggle_font_ready", 32'(font_ready), 32'd1);
        check("toggle_next_addr", 32'(mem_addr), 32'h0F0);
        $display("step wready toggle: %0d bytes accepted over %0d cycles, bad=%0d", exp_idx, guard, bad);

        // Mid-font reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 41; k++) tick;
        check("mid_addr40", 32'(mem_addr), 32'h028);
        check("mid_data40", 32'(mem_wdata), 32'hF0);
        rst = 1'b1;
        tick;
        check_reset_values("midreset");
        rst = 1'b0;
        tick;
        check("restart_we", 32'(mem_we), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_data", 32'(mem_wdata), 32'hF0);
        $display("step mid-sequence reset: restart checked, bad=%0d", bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
